lfsr_rng_server: RTL and testbench

Shares one 8-bit Fibonacci LFSR random-byte source between NREQ requesters using round-robin arbitration. After each delivered byte the LFSR advances STEPS cycles before it serves the next grant, so consecutive bytes are decorrelated. The block sits between the pseudo-random source and consumer blocks (test-pattern generators, scramblers). It also owns seeding of the LFSR.

---
 rtl/lfsr_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/lfsr_rng_server.sv | 118 +++++++++++
 tb/tb_lfsr_rng_server.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR random-byte server: seed constant, tap mask,
// FSM state type and the single-step LFSR function.
package lfsr_pkg;

    localparam logic [7:0] LFSR_INIT = 8'h8A;

    // Feedback taps at bit positions 0, 3, 5 and 6.
    localparam logic [7:0] LFSR_TAPS = 8'b0110_1001;

    typedef enum logic {
        IDLE,
        ADVANCE
    } state_e;

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

    // The all-zero state never leaves itself, so a zero seed is replaced.
    function automatic logic [7:0] lfsr_seed_fix(input logic [7:0] seed);
        return (seed == 8'h00) ? LFSR_INIT : seed;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr+1 with wrap and
// returns a one-hot winner, its index and whether any request was present.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  winner,
    output logic [IW-1:0] win_idx,
    output logic          win_valid
);

    logic [IW-1:0] idx;

    // NOTE: every output gets a default before the search loop so no path
    // through this block leaves a value unassigned, which would infer a latch.
    always_comb begin
        winner    = '0;
        win_idx   = '0;
        win_valid = 1'b0;
        idx       = '0;
        for (int i = 1; i <= N; i++) begin
            idx = IW'((int'(ptr) + i) % N);
            if (!win_valid && req[idx]) begin
                win_valid   = 1'b1;
                winner[idx] = 1'b1;
                win_idx     = idx;
            end
        end
    end

endmodule

// File: rtl/lfsr_rng_server.sv
// Round-robin server handing out bytes of an 8-bit Fibonacci LFSR; the LFSR
// runs STEPS extra shifts after each delivery before the next grant.
module lfsr_rng_server
    import lfsr_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int STEPS = 8,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic            rnd_valid,
    output logic [7:0]      rnd_data,
    output logic [IDW-1:0]  rnd_id,
    input  logic            seed_load,
    input  logic [7:0]      seed,
    output logic            busy
);

    state_e          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [7:0]      s_q, s_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            rnd_valid_q, rnd_valid_d;
    logic [7:0]      rnd_data_q, rnd_data_d;
    logic [IDW-1:0]  rnd_id_q, rnd_id_d;

    logic [NREQ-1:0] arb_winner;
    logic [IDW-1:0]  arb_idx;
    logic            arb_valid;

    rr_arbiter #(
        .N  (NREQ),
        .IW (IDW)
    ) u_arb (
        .req       (req),
        .ptr       (ptr_q),
        .winner    (arb_winner),
        .win_idx   (arb_idx),
        .win_valid (arb_valid)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        s_d         = s_q;
        ptr_d       = ptr_q;
        gnt_d       = '0;
        rnd_valid_d = 1'b0;
        rnd_data_d  = rnd_data_q;
        rnd_id_d    = rnd_id_q;

        unique case (state_q)
            IDLE: begin
                // A seed strobe takes the cycle; pending requests wait one edge.
                if (seed_load) begin
                    s_d = lfsr_seed_fix(seed);
                end else if (arb_valid) begin
                    gnt_d       = arb_winner;
                    rnd_valid_d = 1'b1;
                    rnd_data_d  = s_q;
                    rnd_id_d    = arb_idx;
                    ptr_d       = arb_idx;
                    cnt_d       = 8'(STEPS);
                    state_d     = ADVANCE;
                end
            end
            ADVANCE: begin
                if (seed_load) begin
                    s_d     = lfsr_seed_fix(seed);
                    cnt_d   = 8'h00;
                    state_d = IDLE;
                end else begin
                    s_d   = lfsr_step(s_q);
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= 8'h00;
            s_q         <= LFSR_INIT;
            ptr_q       <= IDW'(NREQ - 1);
            gnt_q       <= '0;
            rnd_valid_q <= 1'b0;
            rnd_data_q  <= 8'h00;
            rnd_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            s_q         <= s_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            rnd_valid_q <= rnd_valid_d;
            rnd_data_q  <= rnd_data_d;
            rnd_id_q    <= rnd_id_d;
        end
    end

    assign gnt       = gnt_q;
    assign rnd_valid = rnd_valid_q;
    assign rnd_data  = rnd_data_q;
    assign rnd_id    = rnd_id_q;
    assign busy      = (state_q == ADVANCE);

endmodule

// File: tb/tb_lfsr_rng_server.sv
// Directed self-checking bench for lfsr_rng_server (NREQ=4, STEPS=8) with
// hand-computed LFSR bytes: 8A -> E0 -> 7B -> 31 at 8 shifts per delivery.
module tb_lfsr_rng_server;

    logic       clk;
    logic       reset_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       rnd_valid;
    logic [7:0] rnd_data;
    logic [1:0] rnd_id;
    logic       seed_load;
    logic [7:0] seed;
    logic       busy;

    int n_pass = 0;
    int n_fail = 0;
    int cycles;
    int busy_cycles;

    lfsr_rng_server #(
        .NREQ  (4),
        .STEPS (8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .gnt       (gnt),
        .rnd_valid (rnd_valid),
        .rnd_data  (rnd_data),
        .rnd_id    (rnd_id),
        .seed_load (seed_load),
        .seed      (seed),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at a sample point; busy is counted from the current sample up to
    // (not including) the sample showing the next grant.
    task automatic wait_grant(input string tag, output int n_cyc, output int n_busy);
        n_cyc  = 0;
        n_busy = 0;
        do begin
            if (busy) n_busy++;
            tick();
            n_cyc++;
        end while (gnt == 4'b0000 && n_cyc < 40);
        check({tag, "_grant_seen"}, 32'(gnt != 4'b0000), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_idle_seen"}, 32'(busy), 32'd0);
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n   = 1'b0;
        req       = 4'b0000;
        seed_load = 1'b0;
        seed      = 8'h00;
        #2;
        check("rst_gnt",       32'(gnt),       32'h0);
        check("rst_rnd_valid", 32'(rnd_valid), 32'h0);
        check("rst_rnd_data",  32'(rnd_data),  32'h0);
        check("rst_rnd_id",    32'(rnd_id),    32'h0);
        check("rst_busy",      32'(busy),      32'h0);
        #5;
        reset_n = 1'b1;

        // Single requester: first byte is the reset state, next is 8 shifts on.
        req = 4'b0001;
        wait_grant("t1_g0", cycles, busy_cycles);
        check("t1_g0_gnt",   32'(gnt),       32'h1);
        check("t1_g0_valid", 32'(rnd_valid), 32'h1);
        check("t1_g0_data",  32'(rnd_data),  32'h8A);
        check("t1_g0_busy",  32'(busy),      32'h1);
        wait_grant("t1_g1", cycles, busy_cycles);
        check("t1_spacing",  32'(cycles),      32'd9);
        check("t1_busy_len", 32'(busy_cycles), 32'd8);
        check("t1_g1_gnt",   32'(gnt),         32'h1);
        check("t1_g1_data",  32'(rnd_data),    32'hE0);

        // All requesters: strict rotation 0,1,2,3,0 with 9-cycle spacing.
        req = 4'b0000;
        tick();
        pulse_reset();
        req = 4'b1111;
        wait_grant("t2_g0", cycles, busy_cycles);
        check("t2_g0_gnt",  32'(gnt),      32'b0001);
        check("t2_g0_id",   32'(rnd_id),   32'd0);
        check("t2_g0_data", 32'(rnd_data), 32'h8A);
        wait_grant("t2_g1", cycles, busy_cycles);
        check("t2_g1_gnt",  32'(gnt),      32'b0010);
        check("t2_g1_id",   32'(rnd_id),   32'd1);
        check("t2_g1_data", 32'(rnd_data), 32'hE0);
        check("t2_g1_sp",   32'(cycles),   32'd9);
        wait_grant("t2_g2", cycles, busy_cycles);
        check("t2_g2_gnt",  32'(gnt),      32'b0100);
        check("t2_g2_id",   32'(rnd_id),   32'd2);
        check("t2_g2_data", 32'(rnd_data), 32'h7B);
        check("t2_g2_sp",   32'(cycles),   32'd9);
        wait_grant("t2_g3", cycles, busy_cycles);
        check("t2_g3_gnt",  32'(gnt),      32'b1000);
        check("t2_g3_id",   32'(rnd_id),   32'd3);
        check("t2_g3_data", 32'(rnd_data), 32'h31);
        check("t2_g3_sp",   32'(cycles),   32'd9);
        wait_grant("t2_g4", cycles, busy_cycles);
        check("t2_g4_gnt",  32'(gnt),      32'b0001);
        check("t2_g4_id",   32'(rnd_id),   32'd0);
        check("t2_g4_sp",   32'(cycles),   32'd9);

        // Round-robin from the pointer when a new requester appears.
        req = 4'b0000;
        tick();
        pulse_reset();
        req = 4'b0101;
        wait_grant("t3_g0", cycles, busy_cycles);
        check("t3_g0_id", 32'(rnd_id), 32'd0);
        req = 4'b0111;
        wait_grant("t3_g1", cycles, busy_cycles);
        check("t3_g1_id",  32'(rnd_id), 32'd1);
        check("t3_g1_gnt", 32'(gnt),    32'b0010);
        wait_grant("t3_g2", cycles, busy_cycles);
        check("t3_g2_id",  32'(rnd_id), 32'd2);
        wait_grant("t3_g3", cycles, busy_cycles);
        check("t3_g3_id",  32'(rnd_id), 32'd0);

        // Seed strobe in IDLE blocks the grant for one cycle, then delivers seed.
        req = 4'b0000;
        tick();
        pulse_reset();
        req       = 4'b0001;
        seed_load = 1'b1;
        seed      = 8'h15;
        tick();
        check("t4_seed_nognt",   32'(gnt),       32'h0);
        check("t4_seed_novalid", 32'(rnd_valid), 32'h0);
        seed_load = 1'b0;
        tick();
        check("t4_seed_gnt",  32'(gnt),      32'h1);
        check("t4_seed_data", 32'(rnd_data), 32'h15);
        req = 4'b0000;
        wait_idle("t4");
        seed_load = 1'b1;
        seed      = 8'h00;
        tick();
        seed_load = 1'b0;
        req       = 4'b0001;
        tick();
        check("t4_zero_gnt",  32'(gnt),      32'h1);
        check("t4_zero_data", 32'(rnd_data), 32'h8A);

        // Seed strobe mid-ADVANCE ends the advance and the seed is delivered as is.
        req = 4'b0000;
        tick();
        pulse_reset();
        req = 4'b0001;
        wait_grant("t5_g0", cycles, busy_cycles);
        req = 4'b0000;
        tick();
        check("t5_gnt_pulse",  32'(gnt),       32'h0);
        check("t5_valid_pulse",32'(rnd_valid), 32'h0);
        check("t5_data_hold",  32'(rnd_data),  32'h8A);
        check("t5_id_hold",    32'(rnd_id),    32'd0);
        tick();
        check("t5_busy_mid",   32'(busy),      32'h1);
        seed_load = 1'b1;
        seed      = 8'h2B;
        tick();
        seed_load = 1'b0;
        check("t5_busy_drop",  32'(busy),      32'h0);
        req = 4'b0001;
        tick();
        check("t5_gnt",  32'(gnt),      32'h1);
        check("t5_data", 32'(rnd_data), 32'h2B);

        // Asynchronous reset in the grant cycle, then re-arbitration from req[0].
        req = 4'b0000;
        tick();
        pulse_reset();
        req = 4'b0010;
        wait_grant("t6_g0", cycles, busy_cycles);
        check("t6_pre_gnt", 32'(gnt), 32'b0010);
        req     = 4'b1111;
        reset_n = 1'b0;
        #1;
        check("t6_async_gnt",   32'(gnt),       32'h0);
        check("t6_async_valid", 32'(rnd_valid), 32'h0);
        check("t6_async_busy",  32'(busy),      32'h0);
        check("t6_async_data",  32'(rnd_data),  32'h0);
        #1;
        reset_n = 1'b1;
        wait_grant("t6_g1", cycles, busy_cycles);
        check("t6_post_gnt",  32'(gnt),      32'b0001);
        check("t6_post_id",   32'(rnd_id),   32'd0);
        check("t6_post_data", 32'(rnd_data), 32'h8A);

        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end

endmodule
